// File: rtl/i2c_xfer_seq.sv
// Autonomous I2C transaction sequencer. Software programs slave address,
// optional register byte, up to four data bytes and GO over APB. The block
// then drives the i2c_master register port through
// INIT, START/address, register byte, repeated START, data bytes and STOP.
// It polls core status after each byte.
//
// Handshakes: APB is zero-wait (PREADY=1) and a write takes effect on the
// clock edge that ends the PSEL&PENABLE&PWRITE cycle. On the core side,
// c_we and c_re are single-cycle strobes, never both high.
// c_do is sampled the cycle after c_re.
module i2c_xfer_seq #(
  parameter int POLL_A = 4,
  parameter int TXRX_A = 3
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        IRQ,
  output logic [5:0]  c_a,
  output logic [7:0]  c_di,
  output logic        c_we,
  output logic        c_re,
  input  logic [7:0]  c_do,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT0, S_INIT1, S_INIT2, S_TX, S_CMD, S_POLL_RD, S_POLL_EV,
    S_RX_RD, S_RX_CAP, S_STOP_CMD, S_STOP_RD, S_STOP_EV, S_FIN
  } state_t;

  typedef enum logic [1:0] {PH_AW, PH_RG, PH_AR, PH_D} phase_t;

  localparam logic [5:0] A_POLL = 6'(POLL_A);
  localparam logic [5:0] A_TXRX = 6'(TXRX_A);

  state_t      state_q, state_n, adv_state;
  phase_t      phase_q, phase_n, adv_phase;
  logic [1:0]  idx_q, idx_n, adv_idx;

  logic        rnw, regen;
  logic [1:0]  nb_m1;
  logic [6:0]  sla;
  logic [7:0]  reg_b;
  logic [31:0] data_r;
  logic        busy, done, nack, al;
  logic [15:0] prescale;
  logic        im;

  logic        wr, start, set_done, set_nack, set_al, clr_busy, cap_en;
  logic [2:0]  sel;
  logic        last, write_type;
  logic [7:0]  tx_byte, cmd_byte;
  logic        unused_paddr;

  assign wr           = PSEL & PENABLE & PWRITE;
  assign sel          = PADDR[4:2];
  assign start        = wr && (sel == 3'd0) && PWDATA[0] && !busy;
  assign PREADY       = 1'b1;
  assign IRQ          = done & im;
  assign dbg_state    = state_q;
  assign unused_paddr = ^{PADDR[7:5], PADDR[1:0]};

  assign last       = (idx_q == nb_m1);
  assign write_type = (phase_q != PH_D) || !rnw;

  // Byte sent in the TX step and command sent in the CMD step of the current phase.
  always_comb begin
    tx_byte  = data_r[{idx_q, 3'b000} +: 8];
    cmd_byte = 8'h90;
    case (phase_q)
      PH_AW: begin tx_byte = {sla, 1'b0}; cmd_byte = 8'h90; end
      PH_RG: begin tx_byte = reg_b;       cmd_byte = 8'h10; end
      PH_AR: begin tx_byte = {sla, 1'b1}; cmd_byte = 8'h90; end
      default: begin
        if (rnw) cmd_byte = last ? 8'h68 : 8'h20;
        else     cmd_byte = last ? 8'h50 : 8'h10;
      end
    endcase
  end

  // Next phase after a successful one; read bytes skip the TX step.
  always_comb begin
    adv_phase = phase_q;
    adv_idx   = idx_q;
    adv_state = S_TX;
    case (phase_q)
      PH_AW: begin adv_phase = regen ? PH_RG : PH_D; adv_idx = 2'd0; end
      PH_RG: begin adv_phase = rnw ? PH_AR : PH_D;   adv_idx = 2'd0; end
      PH_AR: begin adv_phase = PH_D;                 adv_idx = 2'd0; end
      default: begin
        if (last) adv_state = S_FIN;
        else      adv_idx = idx_q + 2'd1;
      end
    endcase
    if (adv_state != S_FIN && adv_phase == PH_D && rnw) adv_state = S_CMD;
  end

  // Sequencer next-state and core-port strobes.
  always_comb begin
    state_n  = state_q;
    phase_n  = phase_q;
    idx_n    = idx_q;
    c_a      = 6'd0;
    c_di     = 8'd0;
    c_we     = 1'b0;
    c_re     = 1'b0;
    set_done = 1'b0;
    set_nack = 1'b0;
    set_al   = 1'b0;
    clr_busy = 1'b0;
    cap_en   = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_n = S_INIT0;
      S_INIT0: begin c_we = 1'b1; c_a = 6'd0; c_di = prescale[7:0];  state_n = S_INIT1; end
      S_INIT1: begin c_we = 1'b1; c_a = 6'd1; c_di = prescale[15:8]; state_n = S_INIT2; end
      S_INIT2: begin
        c_we    = 1'b1;
        c_a     = 6'd2;
        c_di    = 8'h80;
        phase_n = (regen || !rnw) ? PH_AW : PH_AR;
        idx_n   = 2'd0;
        state_n = S_TX;
      end
      S_TX:      begin c_we = 1'b1; c_a = A_TXRX; c_di = tx_byte;  state_n = S_CMD; end
      S_CMD:     begin c_we = 1'b1; c_a = A_POLL; c_di = cmd_byte; state_n = S_POLL_RD; end
      S_POLL_RD: begin c_re = 1'b1; c_a = A_POLL; state_n = S_POLL_EV; end
      S_POLL_EV: begin
        if (c_do[1]) begin
          state_n = S_POLL_RD;
        end else if (c_do[5]) begin
          set_al   = 1'b1;
          set_done = 1'b1;
          clr_busy = 1'b1;
          state_n  = S_IDLE;
        end else if (c_do[7] && write_type) begin
          set_nack = 1'b1;
          state_n  = S_STOP_CMD;
        end else if (!write_type) begin
          state_n = S_RX_RD;
        end else begin
          phase_n = adv_phase;
          idx_n   = adv_idx;
          state_n = adv_state;
        end
      end
      S_RX_RD:  begin c_re = 1'b1; c_a = A_TXRX; state_n = S_RX_CAP; end
      S_RX_CAP: begin
        cap_en  = 1'b1;
        phase_n = adv_phase;
        idx_n   = adv_idx;
        state_n = adv_state;
      end
      S_STOP_CMD: begin c_we = 1'b1; c_a = A_POLL; c_di = 8'h40; state_n = S_STOP_RD; end
      S_STOP_RD:  begin c_re = 1'b1; c_a = A_POLL; state_n = S_STOP_EV; end
      S_STOP_EV: begin
        if (c_do[5]) set_al = 1'b1;
        state_n = c_do[1] ? S_STOP_RD : S_FIN;
      end
      S_FIN: begin set_done = 1'b1; clr_busy = 1'b1; state_n = S_IDLE; end
      default: state_n = S_IDLE;
    endcase
  end

  // Sequencer state, current phase and data byte index.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      phase_q <= PH_AW;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      idx_q   <= idx_n;
    end
  end

  // Register file: APB writes (locked while busy), W1C status, sequencer updates.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rnw <= 1'b0; regen <= 1'b0; nb_m1 <= 2'd0;
      sla <= 7'd0; reg_b <= 8'd0; data_r <= 32'd0;
      busy <= 1'b0; done <= 1'b0; nack <= 1'b0; al <= 1'b0;
      prescale <= 16'd0; im <= 1'b0;
    end else begin
      if (wr && !busy) begin
        case (sel)
          3'd0: begin rnw <= PWDATA[1]; nb_m1 <= PWDATA[3:2]; regen <= PWDATA[4]; end
          3'd1: begin sla <= PWDATA[6:0]; reg_b <= PWDATA[15:8]; end
          3'd2: data_r <= PWDATA;
          3'd4: prescale <= PWDATA[15:0];
          default: ;
        endcase
      end
      if (wr && sel == 3'd5) im <= PWDATA[0];
      if (wr && sel == 3'd3) begin
        if (PWDATA[1]) done <= 1'b0;
        if (PWDATA[2]) nack <= 1'b0;
        if (PWDATA[3]) al   <= 1'b0;
      end
      if (start) begin
        busy <= 1'b1; done <= 1'b0; nack <= 1'b0; al <= 1'b0;
      end
      if (set_done) done <= 1'b1;
      if (set_nack) nack <= 1'b1;
      if (set_al)   al   <= 1'b1;
      if (clr_busy) busy <= 1'b0;
      if (cap_en)   data_r[{idx_q, 3'b000} +: 8] <= c_do;
    end
  end

  // APB read mux.
  always_comb begin
    PRDATA = 32'd0;
    case (sel)
      3'd0: PRDATA = {27'd0, regen, nb_m1, rnw, 1'b0};
      3'd1: PRDATA = {16'd0, reg_b, 1'b0, sla};
      3'd2: PRDATA = data_r;
      3'd3: PRDATA = {28'd0, al, nack, done, busy};
      3'd4: PRDATA = {16'd0, prescale};
      3'd5: PRDATA = {31'd0, im};
      default: PRDATA = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Bench for i2c_xfer_seq: a behavioural i2c_master register model answers the
// sequencer, and a phase-list reference model predicts the core write log,
// STATUS, DATA and the number of status polls.
module tb_i2c_xfer_seq;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, IRQ;
  logic [5:0]  c_a;
  logic [7:0]  c_di, c_do;
  logic        c_we, c_re;
  logic [3:0]  dbg_state;

  localparam logic [7:0] R_CTRL = 8'h00, R_ADDR = 8'h04, R_DATA = 8'h08;
  localparam logic [7:0] R_STAT = 8'h0C, R_PRE = 8'h10, R_IM = 8'h14;

  i2c_xfer_seq #(.POLL_A(4), .TXRX_A(3)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .IRQ(IRQ), .c_a(c_a), .c_di(c_di), .c_we(c_we),
    .c_re(c_re), .c_do(c_do), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;

  // ---------------- core model state ----------------
  logic [13:0] log_q[$];
  logic [13:0] exp_q[$];
  logic [7:0]  rx_q[$];
  int cmd_k, tip_left, tip_n, nack_cmd, al_cmd, sr_reads, both_cnt;
  bit rx_ack_f, al_f;

  // ---------------- transaction config / expectations ----------------
  bit          cfg_rnw, cfg_regen;
  int          cfg_nb, cfg_nack, cfg_al, cfg_tip;
  logic [6:0]  cfg_sla;
  logic [7:0]  cfg_reg;
  logic [31:0] cfg_data;
  logic [15:0] cfg_pre;
  logic [7:0]  rx_v[4];
  logic [31:0] exp_data, exp_status;
  int          exp_sr;
  logic [31:0] got_status, got_data;

  // i2c_master register port model: logs writes, answers SR/RXR reads one cycle later.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      c_do <= 8'h00;
    end else begin
      if (c_we && c_re) both_cnt++;
      if (c_we) begin
        log_q.push_back({c_a, c_di});
        if (c_a == 6'd4) begin
          tip_left = tip_n;
          rx_ack_f = (cmd_k == nack_cmd);
          al_f     = (cmd_k == al_cmd);
          cmd_k++;
        end
      end
      if (c_re && c_a == 6'd4) begin
        sr_reads++;
        if (tip_left > 0) begin
          c_do <= 8'h02;
          tip_left--;
        end else begin
          c_do <= {rx_ack_f, 1'b0, al_f, 5'b00000};
        end
      end else if (c_re && c_a == 6'd3) begin
        if (rx_q.size() > 0) c_do <= rx_q.pop_front();
        else                 c_do <= 8'h00;
      end
    end
  end

  // Reference model: list of phases, each contributing TX/CMD writes and one command.
  task automatic build_exp();
    int kinds[$];
    int b, base, ncmd;
    bit wt, last;
    logic [7:0] tx, cmd;
    exp_q.delete();
    exp_q.push_back({6'd0, cfg_pre[7:0]});
    exp_q.push_back({6'd1, cfg_pre[15:8]});
    exp_q.push_back({6'd2, 8'h80});
    if (cfg_regen || !cfg_rnw) kinds.push_back(0);
    if (cfg_regen) kinds.push_back(1);
    if (cfg_rnw) kinds.push_back(2);
    base = kinds.size();
    for (int i = 0; i < cfg_nb; i++) kinds.push_back(3);
    exp_data = cfg_data;
    exp_status = 32'h2;
    ncmd = 0;
    for (int k = 0; k < kinds.size(); k++) begin
      b = k - base;
      last = (b == cfg_nb - 1);
      tx = 8'h00;
      case (kinds[k])
        0: begin tx = {cfg_sla, 1'b0}; cmd = 8'h90; end
        1: begin tx = cfg_reg;         cmd = 8'h10; end
        2: begin tx = {cfg_sla, 1'b1}; cmd = 8'h90; end
        default: begin
          tx = cfg_data[8*b +: 8];
          if (cfg_rnw) cmd = last ? 8'h68 : 8'h20;
          else         cmd = last ? 8'h50 : 8'h10;
        end
      endcase
      wt = !(kinds[k] == 3 && cfg_rnw);
      if (wt) exp_q.push_back({6'd3, tx});
      exp_q.push_back({6'd4, cmd});
      ncmd++;
      if (k == cfg_al) begin exp_status = 32'hA; break; end
      if (wt && k == cfg_nack) begin
        exp_q.push_back({6'd4, 8'h40});
        ncmd++;
        exp_status = 32'h6;
        break;
      end
      if (!wt) exp_data[8*b +: 8] = rx_v[b];
    end
    exp_sr = ncmd * (cfg_tip + 1);
  endtask

  function automatic int first_diff();
    if (log_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (log_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = 32'h0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  task automatic random_cfg();
    int nph, kind;
    cfg_rnw   = 1'($urandom_range(0, 1));
    cfg_regen = 1'($urandom_range(0, 1));
    cfg_nb    = $urandom_range(1, 4);
    cfg_sla   = 7'($urandom);
    cfg_reg   = 8'($urandom);
    cfg_data  = $urandom;
    cfg_pre   = 16'($urandom);
    cfg_tip   = $urandom_range(0, 2);
    foreach (rx_v[i]) rx_v[i] = 8'($urandom);
    nph = cfg_nb + ((cfg_regen || !cfg_rnw) ? 1 : 0) + (cfg_regen ? 1 : 0) + (cfg_rnw ? 1 : 0);
    kind = $urandom_range(0, 2);
    cfg_nack = (kind == 1) ? $urandom_range(0, nph - 1) : -1;
    cfg_al   = (kind == 2) ? $urandom_range(0, nph - 1) : -1;
  endtask

  // Arms the core model, programs the block and writes GO (returns in cycle N+1).
  task automatic start_xfer();
    build_exp();
    log_q.delete();
    rx_q.delete();
    foreach (rx_v[i]) rx_q.push_back(rx_v[i]);
    cmd_k = 0; sr_reads = 0; both_cnt = 0; tip_left = 0;
    tip_n = cfg_tip; nack_cmd = cfg_nack; al_cmd = cfg_al;
    rx_ack_f = 1'b0; al_f = 1'b0;
    apb_write(R_PRE, {16'd0, cfg_pre});
    apb_write(R_ADDR, {16'd0, cfg_reg, 1'b0, cfg_sla});
    apb_write(R_DATA, cfg_data);
    apb_write(R_IM, 32'h1);
    apb_write(R_CTRL, {27'd0, cfg_regen, 2'(cfg_nb - 1), cfg_rnw, 1'b1});
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    PADDR = R_STAT;
    @(negedge PCLK);
    while (PRDATA[0] !== 1'b0 && n < 5000) begin
      @(negedge PCLK);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      failures++;
      $display("FAIL %s timeout: BUSY still %b after %0d cycles, need 0", nm, PRDATA[0], n);
    end
    apb_read(R_STAT, got_status);
    apb_read(R_DATA, got_data);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] v;
    logic [7:0] regs[6];
    regs = '{R_CTRL, R_ADDR, R_DATA, R_STAT, R_PRE, R_IM};
    checks++;
    if ({c_we, c_re, c_a, c_di, IRQ} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b re=%b a=%h di=%h irq=%b, need all 0", c_we, c_re, c_a, c_di, IRQ);
    end
    for (int i = 0; i < 6; i++) begin
      apb_read(regs[i], v);
      checks++;
      if (v !== 32'd0) begin
        failures++;
        $display("FAIL reset_reg_%h: got %h need 00000000", regs[i], v);
      end
    end
  endtask

  task automatic test_write();
    int d;
    logic [13:0] tbl[8];
    tbl = '{{6'd3, 8'hA0}, {6'd4, 8'h90}, {6'd3, 8'h10}, {6'd4, 8'h10},
            {6'd3, 8'hAA}, {6'd4, 8'h10}, {6'd3, 8'hBB}, {6'd4, 8'h50}};
    cfg_rnw = 0; cfg_regen = 1; cfg_nb = 2; cfg_sla = 7'h50; cfg_reg = 8'h10;
    cfg_data = 32'h0000BBAA; cfg_pre = 16'h1234; cfg_tip = 1; cfg_nack = -1; cfg_al = -1;
    start_xfer();
    checks++;
    if (!(c_we === 1'b1 && c_a === 6'd0 && c_di === 8'h34)) begin
      failures++;
      $display("FAIL go_first_init: got we=%b a=%h di=%h need we=1 a=00 di=34", c_we, c_a, c_di);
    end
    PADDR = R_STAT;
    #1;
    checks++;
    if (PRDATA[0] !== 1'b1) begin
      failures++;
      $display("FAIL go_busy: got %b need 1", PRDATA[0]);
    end
    wait_idle("write");
    checks++;
    d = 0;
    if (log_q.size() != 11) d = 1;
    else for (int i = 0; i < 8; i++) if (log_q[3+i] !== tbl[i]) d = 1;
    if (d != 0) begin
      failures++;
      $display("FAIL write_seq_const: got %0d writes, need 11 matching vector", log_q.size());
    end
    checks++;
    if (got_status !== 32'h2 || IRQ !== 1'b1) begin
      failures++;
      $display("FAIL write_status: got %h irq=%b need 00000002 irq=1", got_status, IRQ);
    end
  endtask

  task automatic test_read();
    int d;
    cfg_rnw = 1; cfg_regen = 1; cfg_nb = 4; cfg_sla = 7'h50; cfg_reg = 8'h20;
    cfg_data = 32'hDEADBEEF; cfg_pre = 16'h0010; cfg_tip = 0; cfg_nack = -1; cfg_al = -1;
    rx_v = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_xfer();
    wait_idle("read");
    d = first_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL read_seq: diff at %0d, got %0d writes need %0d", d, log_q.size(), exp_q.size());
    end
    checks++;
    if (log_q.size() < 9 || log_q[7] !== {6'd3, 8'hA1} || log_q[8] !== {6'd4, 8'h90}) begin
      failures++;
      $display("FAIL read_ar_phase: AR writes wrong, need a3=A1 a4=90");
    end
    checks++;
    if (log_q.size() == 0 || log_q[log_q.size()-1] !== {6'd4, 8'h68}) begin
      failures++;
      $display("FAIL read_last_cmd: need a4=68");
    end
    checks++;
    if (got_data !== 32'h44332211 || got_status !== 32'h2) begin
      failures++;
      $display("FAIL read_data: got %h status %h need 44332211 status 00000002", got_data, got_status);
    end
  endtask

  task automatic test_nack();
    cfg_rnw = 0; cfg_regen = 1; cfg_nb = 3; cfg_sla = 7'h2A; cfg_reg = 8'h05;
    cfg_data = 32'h00CCBBAA; cfg_pre = 16'h0020; cfg_tip = 1; cfg_nack = 0; cfg_al = -1;
    start_xfer();
    wait_idle("nack");
    checks++;
    if (log_q.size() != 6 || log_q[5] !== {6'd4, 8'h40}) begin
      failures++;
      $display("FAIL nack_seq: got %0d writes, need 6 ending a4=40", log_q.size());
    end
    checks++;
    if (got_status !== 32'h6 || IRQ !== 1'b1) begin
      failures++;
      $display("FAIL nack_status: got %h irq=%b need 00000006 irq=1", got_status, IRQ);
    end
  endtask

  task automatic test_al();
    int sto;
    cfg_rnw = 1; cfg_regen = 1; cfg_nb = 2; cfg_sla = 7'h33; cfg_reg = 8'h44;
    cfg_data = 32'h0; cfg_pre = 16'h0008; cfg_tip = 2; cfg_nack = -1; cfg_al = 1;
    start_xfer();
    wait_idle("al");
    sto = 0;
    foreach (log_q[i]) if (log_q[i][13:8] == 6'd4 && log_q[i][6]) sto++;
    checks++;
    if (sto != 0 || first_diff() != -1) begin
      failures++;
      $display("FAIL al_seq: got %0d STO writes and %0d writes, need 0 STO and %0d writes", sto, log_q.size(), exp_q.size());
    end
    checks++;
    if (got_status !== 32'hA) begin
      failures++;
      $display("FAIL al_status: got %h need 0000000a", got_status);
    end
  endtask

  task automatic test_tip_protect();
    logic [31:0] v;
    cfg_rnw = 0; cfg_regen = 0; cfg_nb = 1; cfg_sla = 7'h11; cfg_reg = 8'h99;
    cfg_data = 32'h000000C3; cfg_pre = 16'h0100; cfg_tip = 5; cfg_nack = -1; cfg_al = -1;
    start_xfer();
    apb_write(R_ADDR, 32'h0000_FF7F);
    apb_write(R_DATA, 32'h5A5A_5A5A);
    apb_read(R_ADDR, v);
    checks++;
    if (v !== {16'd0, cfg_reg, 1'b0, cfg_sla}) begin
      failures++;
      $display("FAIL busy_addr_lock: got %h need %h", v, {16'd0, cfg_reg, 1'b0, cfg_sla});
    end
    apb_read(R_DATA, v);
    checks++;
    if (v !== cfg_data) begin
      failures++;
      $display("FAIL busy_data_lock: got %h need %h", v, cfg_data);
    end
    wait_idle("tip");
    checks++;
    if (sr_reads != exp_sr || first_diff() != -1) begin
      failures++;
      $display("FAIL tip_polls: got %0d SR reads need %0d", sr_reads, exp_sr);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [31:0] v;
    cfg_rnw = 1; cfg_regen = 0; cfg_nb = 4; cfg_sla = 7'h0F; cfg_reg = 8'h00;
    cfg_data = 32'h0; cfg_pre = 16'h0004; cfg_tip = 1; cfg_nack = -1; cfg_al = -1;
    foreach (rx_v[i]) rx_v[i] = 8'($urandom);
    start_xfer();
    n = 0;
    while (cmd_k < 3 && n < 2000) begin @(posedge PCLK); n++; end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL rstmid_reach_d: got %0d commands need 3", cmd_k);
    end
    @(negedge PCLK);
    #2;
    PRESETn = 1'b0;
    #1;
    checks++;
    if ({c_we, c_re, c_a, c_di, IRQ} !== 17'd0) begin
      failures++;
      $display("FAIL rstmid_outputs: got we=%b re=%b a=%h di=%h irq=%b need 0", c_we, c_re, c_a, c_di, IRQ);
    end
    for (int i = 0; i < 6; i++) begin
      PADDR = 8'(4 * i);
      #1;
      v = PRDATA;
      checks++;
      if (v !== 32'd0) begin
        failures++;
        $display("FAIL rstmid_reg_%0d: got %h need 00000000", i, v);
      end
    end
    @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    random_cfg();
    cfg_nack = -1; cfg_al = -1;
    start_xfer();
    wait_idle("rstmid_fresh");
    checks++;
    if (first_diff() != -1 || got_status !== 32'h2 || got_data !== exp_data) begin
      failures++;
      $display("FAIL rstmid_fresh: got status %h data %h need %h %h", got_status, got_data, 32'h2, exp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    cfg_rnw = 0; cfg_regen = 0; cfg_nb = 1; cfg_sla = 7'h21; cfg_reg = 8'h00;
    cfg_data = 32'h0000007E; cfg_pre = 16'h0002; cfg_tip = 2; cfg_nack = -1; cfg_al = -1;
    start_xfer();
    apb_write(R_CTRL, 32'h0000_001F);
    wait_idle("b2b_first");
    checks++;
    if (first_diff() != -1) begin
      failures++;
      $display("FAIL b2b_go_ignored: got %0d writes need %0d", log_q.size(), exp_q.size());
    end
    apb_write(R_STAT, 32'h2);
    apb_read(R_STAT, v);
    checks++;
    if (v !== 32'h0 || IRQ !== 1'b0) begin
      failures++;
      $display("FAIL w1c_done: got %h irq=%b need 00000000 irq=0", v, IRQ);
    end
    random_cfg();
    start_xfer();
    wait_idle("b2b_second");
    checks++;
    if (first_diff() != -1 || got_status !== exp_status) begin
      failures++;
      $display("FAIL b2b_second: got status %h need %h", got_status, exp_status);
    end
    apb_write(R_IM, 32'h0);
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL irq_mask: got %b need 0", IRQ);
    end
  endtask

  task automatic test_random();
    int d;
    for (int it = 0; it < 12; it++) begin
      random_cfg();
      start_xfer();
      wait_idle("random");
      d = first_diff();
      checks++;
      if (d != -1) begin
        failures++;
        $display("FAIL rand%0d_seq: diff at %0d got %0d writes need %0d", it, d, log_q.size(), exp_q.size());
      end
      checks++;
      if (got_status !== exp_status || got_data !== exp_data || IRQ !== exp_status[1]) begin
        failures++;
        $display("FAIL rand%0d_result: got status %h data %h irq %b need %h %h %b",
                 it, got_status, got_data, IRQ, exp_status, exp_data, exp_status[1]);
      end
      checks++;
      if (sr_reads != exp_sr || both_cnt != 0) begin
        failures++;
        $display("FAIL rand%0d_polls: got %0d SR reads, %0d dual strobes, need %0d and 0", it, sr_reads, both_cnt, exp_sr);
      end
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    cmd_k = 0; tip_left = 0; tip_n = 0; nack_cmd = -1; al_cmd = -1;
    sr_reads = 0; both_cnt = 0; rx_ack_f = 0; al_f = 0;
    do_reset();
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_al();
    test_tip_protect();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
